// File: rtl/txfifo_pkt_arbiter.sv
// Round-robin arbiter that frames one packet per grant (4-byte header plus payload)
// onto the single TX FIFO write port of the FT245 protocol master.
module txfifo_pkt_arbiter #(
  parameter int          N_SRC     = 4,
  parameter int          LEN_W     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     en,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC*LEN_W-1:0]   src_len,
  output logic [N_SRC-1:0]         src_grant,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*8-1:0]       src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic [7:0]               txfifo_data,
  output logic                     txfifo_wr,
  input  logic                     txfifo_full,
  output logic                     busy,
  output logic [15:0]              pkt_cnt
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;

  logic              win_found_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [LEN_W-1:0]  win_len_s;
  logic              sel_valid_s;
  logic [7:0]        sel_data_s;
  logic [15:0]       len16_s;
  logic              xfer_s;
  int                arb_j;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    arb_j       = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      arb_j = int'(last_q) + k;
      arb_j = (arb_j >= N_SRC) ? (arb_j - N_SRC) : arb_j;
      if (!win_found_s && src_req[arb_j]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(arb_j);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Slice muxes: length of the arbitration winner, payload of the granted source.
  always_comb begin
    win_len_s   = '0;
    sel_valid_s = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      win_len_s   = (win_idx_s == IDX_W'(i)) ? src_len[i*LEN_W +: LEN_W] : win_len_s;
      sel_valid_s = (idx_q == IDX_W'(i)) ? src_valid[i] : sel_valid_s;
      sel_data_s  = (idx_q == IDX_W'(i)) ? src_data[i*8 +: 8] : sel_data_s;
    end
  end

  assign len16_s = 16'(len_q);

  // Next-state and FIFO-side outputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    last_d      = last_q;
    len_d       = len_q;
    rem_d       = rem_q;
    hcnt_d      = hcnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    txfifo_wr   = 1'b0;
    txfifo_data = 8'h00;
    src_ready   = '0;
    xfer_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && win_found_s) begin
          state_d = S_HDR;
          grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx_s;
          idx_d   = win_idx_s;
          last_d  = win_idx_s;
          len_d   = win_len_s;
          hcnt_d  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        txfifo_wr = ~txfifo_full;
        case (hcnt_q)
          2'd0:    txfifo_data = SYNC_BYTE;
          2'd1:    txfifo_data = 8'(idx_q);
          2'd2:    txfifo_data = len16_s[7:0];
          2'd3:    txfifo_data = len16_s[15:8];
          default: txfifo_data = 8'h00;
        endcase
        if (!txfifo_full) begin
          hcnt_d = hcnt_q + 2'd1;
          rem_d  = (hcnt_q == 2'd3) ? len_q : rem_q;
          if (hcnt_q == 2'd3 && len_q == '0) begin
            state_d   = S_IDLE;
            grant_d   = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else if (hcnt_q == 2'd3) begin
            state_d = S_PAY;
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAY: begin
        src_ready   = grant_q & {N_SRC{~txfifo_full}};
        txfifo_data = sel_data_s;
        xfer_s      = sel_valid_s & ~txfifo_full;
        txfifo_wr   = xfer_s;
        if (xfer_s) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = S_IDLE;
            grant_d   = '0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            state_d = S_PAY;
          end
        end else begin
          state_d = S_PAY;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last starts at N_SRC-1 so source 0 wins the first arbitration.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_SRC - 1);
      len_q     <= '0;
      rem_q     <= '0;
      hcnt_q    <= 2'd0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      hcnt_q    <= hcnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign src_grant = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_txfifo_pkt_arbiter.sv
// Scoreboard bench for txfifo_pkt_arbiter: a packet-level model predicts grant order
// and the byte stream; an independent monitor compares every FIFO write.
module tb_txfifo_pkt_arbiter;
  localparam int N  = 4;
  localparam int LW = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              en;
  logic [N-1:0]      src_req;
  logic [N*LW-1:0]   src_len;
  logic [N-1:0]      src_grant;
  logic [N-1:0]      src_valid;
  logic [N*8-1:0]    src_data;
  logic [N-1:0]      src_ready;
  logic [7:0]        txfifo_data;
  logic              txfifo_wr;
  logic              txfifo_full;
  logic              busy;
  logic [15:0]       pkt_cnt;

  txfifo_pkt_arbiter #(.N_SRC(N), .LEN_W(LW), .SYNC_BYTE(8'hA5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
    .src_req(src_req), .src_len(src_len), .src_grant(src_grant),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr), .txfifo_full(txfifo_full),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          exp_g[$];
  logic [7:0]  pay [N][512];
  int          plen [N];
  int          ptr  [N];
  logic [N-1:0] new_req;
  logic        en_nxt;
  bit          rand_full, rand_valid;
  int          m_last;
  logic [15:0] m_pkt;
  bit          any_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_g.delete();
    for (int i = 0; i < N; i++) begin
      plen[i] = 0;
      ptr[i]  = 0;
    end
  endtask

  // One clock: drive sources at negedge, then record accepted bytes just before posedge.
  task automatic cycle();
    @(negedge sys_clk);
    en = en_nxt;
    src_req = src_req | new_req;
    new_req = '0;
    txfifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_grant[i]) begin
        src_req[i] = 1'b0;
        src_len[i*LW +: LW] = LW'($urandom);
      end
      src_valid[i] = (ptr[i] < plen[i]) && (!rand_valid || $urandom_range(0, 3) != 0);
      src_data[i*8 +: 8] = (ptr[i] < plen[i]) ? pay[i][ptr[i]] : 8'($urandom);
    end
    #4;
    for (int i = 0; i < N; i++)
      if (src_valid[i] && src_ready[i]) ptr[i]++;
  endtask

  // Issue requests for every source in mask and predict the resulting packets.
  task automatic start_round(input logic [N-1:0] mask, input int fixed_len, input bit fixed_pay);
    logic [N-1:0] pending;
    int j;
    pending = mask;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (fixed_len >= 0) plen[i] = fixed_len;
        else if ($urandom_range(0, 15) == 0) plen[i] = 300;
        else plen[i] = $urandom_range(0, 9);
        ptr[i] = 0;
        for (int k = 0; k < plen[i]; k++)
          pay[i][k] = fixed_pay ? 8'((k + 1) * 17) : 8'($urandom);
        src_len[i*LW +: LW] = LW'(plen[i]);
      end
    end
    while (pending != '0) begin
      j = 0;
      for (int k = N; k >= 1; k--)
        if (pending[(m_last + k) % N]) j = (m_last + k) % N;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(j));
      exp_q.push_back(8'(plen[j]));
      exp_q.push_back(8'(plen[j] >> 8));
      for (int k = 0; k < plen[j]; k++) exp_q.push_back(pay[j][k]);
      exp_g.push_back(j);
      m_last = j;
      pending[j] = 1'b0;
      m_pkt = m_pkt + 16'd1;
    end
    new_req = mask;
  endtask

  task automatic wait_round(input string name);
    int c;
    c = 0;
    while (c < 4000 && !(exp_q.size() == 0 && exp_g.size() == 0 && busy == 1'b0
                         && src_req == '0 && new_req == '0)) begin
      cycle();
      c++;
    end
    if (c >= 4000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: %0d bytes and %0d grants still expected", name, exp_q.size(), exp_g.size());
      flush_model();
    end
    chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(m_pkt));
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: compares each FIFO write and each new grant against the predictions.
  initial begin
    logic [N-1:0] prev_g;
    int idle_run;
    int gi;
    prev_g = '0;
    idle_run = 0;
    forever begin
      @(negedge sys_clk);
      #4;
      if (sys_rst_n) begin
        any_ready = any_ready | (|src_ready);
        chk("ready_only_granted", 32'(src_ready & ~src_grant), 32'd0);
        chk("ready_while_full", 32'(txfifo_full && (|src_ready)), 32'd0);
        if (txfifo_wr) begin
          chk("wr_while_full", 32'(txfifo_full), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got %0h expected no write", txfifo_data);
          end else begin
            chk("fifo_byte", 32'(txfifo_data), 32'(exp_q.pop_front()));
          end
        end
        if (src_grant != '0 && prev_g == '0) begin
          chk("grant_onehot", 32'($onehot(src_grant)), 32'd1);
          gi = 0;
          for (int i = 0; i < N; i++) if (src_grant[i]) gi = i;
          if (exp_g.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant: got %0d expected none", gi);
          end else begin
            chk("grant_order", 32'(gi), 32'(exp_g.pop_front()));
          end
        end
        if (!busy && en && (|src_req)) begin
          checks++;
          if (idle_run >= 1) begin
            failures++;
            $display("FAIL idle_gap: got %0d idle cycles expected 1", idle_run + 1);
          end
          idle_run++;
        end else begin
          idle_run = 0;
        end
        prev_g = src_grant;
      end else begin
        prev_g = '0;
        idle_run = 0;
      end
    end
  end

  initial begin
    int c;
    sys_rst_n = 1'b0;
    en = 1'b1; en_nxt = 1'b1;
    src_req = '0; src_len = '0; src_valid = '0; src_data = '0;
    txfifo_full = 1'b0; new_req = '0;
    rand_full = 1'b0; rand_valid = 1'b0; any_ready = 1'b0;
    m_last = N - 1; m_pkt = 16'd0;
    flush_model();
    repeat (3) @(negedge sys_clk);
    #4;
    chk("rst_grant", 32'(src_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_wr", 32'(txfifo_wr), 32'd0);
    chk("rst_data", 32'(txfifo_data), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single packet: source 1, payload 11,22,33, written on 7 consecutive cycles.
    start_round(4'b0010, 3, 1'b1);
    c = 0;
    while (c < 20 && src_grant == '0) begin cycle(); c++; end
    chk("grant_latency", 32'(c), 32'd2);
    chk("single_wr_c0", 32'(txfifo_wr), 32'd1);
    for (int k = 1; k < 7; k++) begin
      cycle();
      chk("single_wr_run", 32'(txfifo_wr), 32'd1);
    end
    wait_round("single");

    // Round robin among 0, 2, 3 with len=1.
    start_round(4'b1101, 1, 1'b0);
    wait_round("rr1");
    start_round(4'b1101, 1, 1'b0);
    wait_round("rr2");

    // Zero length on source 2.
    any_ready = 1'b0;
    start_round(4'b0100, 0, 1'b0);
    wait_round("zero");
    chk("zero_no_ready", 32'(any_ready), 32'd0);

    // Backpressure: random full and valid gaps on a len=4 packet.
    rand_full = 1'b1; rand_valid = 1'b1;
    start_round(4'b0001, 4, 1'b0);
    wait_round("bp");

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      rand_full  = ($urandom_range(0, 1) == 1);
      rand_valid = ($urandom_range(0, 1) == 1);
      start_round(4'($urandom_range(1, 15)), -1, 1'b0);
      wait_round("rand");
    end
    rand_full = 1'b0; rand_valid = 1'b0;

    // Enable gating: drop en during the first packet while another source waits.
    start_round(4'b0011, 5, 1'b0);
    c = 0;
    while (c < 20 && busy == 1'b0) begin cycle(); c++; end
    en_nxt = 1'b0;
    c = 0;
    while (c < 50 && busy == 1'b1) begin cycle(); c++; end
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("en_gate_grant", 32'(src_grant), 32'd0);
      chk("en_gate_busy", 32'(busy), 32'd0);
    end
    en_nxt = 1'b1;
    wait_round("en_gate");

    // Reset mid-payload: outputs clear at once; source 0 wins afterwards.
    start_round(4'b0100, 20, 1'b0);
    c = 0;
    while (c < 50 && ptr[2] < 3) begin cycle(); c++; end
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(src_grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr", 32'(txfifo_wr), 32'd0);
    chk("arst_data", 32'(txfifo_data), 32'd0);
    chk("arst_ready", 32'(src_ready), 32'd0);
    chk("arst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    flush_model();
    src_req = '0; new_req = '0;
    m_last = N - 1; m_pkt = 16'd0;
    cycle(); cycle();
    #3;
    sys_rst_n = 1'b1;
    start_round(4'b1111, 2, 1'b0);
    wait_round("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
